// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - control and handshake bundle between mc_ctrl_fsm and the MIPS datapath
interface mc_ctrl_fsm_if;
    logic       start_i;
    logic       stop_i;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       zero;
    logic       mem_ready_i;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       busy_o;
    logic       err_o;
    logic [1:0] err_code;

    modport master (
        input  start_i, stop_i, op_i, funct_i, zero, mem_ready_i,
        output pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_srca, alu_srcb, alu_op, pc_src, busy_o, err_o, err_code
    );

    modport slave (
        output start_i, stop_i, op_i, funct_i, zero, mem_ready_i,
        input  pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_srca, alu_srcb, alu_op, pc_src, busy_o, err_o, err_code
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS control sequencer with memory ready handshake, watchdog and sticky error
// Optional feature macro: MC_CTRL_BNE_EN (adds the bne instruction, op 0x05).
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst_n,
    mc_ctrl_fsm_if.master bus
);
`ifdef MC_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    // The cycle that would bring the wait count to MEM_TIMEOUT is the deciding cycle.
    localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT - 1);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OP      = 2'b01;
    localparam logic [1:0] ERR_FUNCT   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE_EX, S_RTYPE_WB, S_ADDI_EX, S_ADDI_WB, S_BEQ, S_BNE, S_JUMP, S_ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    state_t      boundary_next;
    logic [15:0] wait_cnt;
    logic [1:0]  err_q;
    logic [1:0]  err_next;
    logic [3:0]  rtype_alu_q;
    logic        funct_ok;
    logic [3:0]  funct_alu;
    logic        wait_state;
    logic        timeout;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_AND;
        case (bus.funct_i)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    assign wait_state    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout       = wait_state && !bus.mem_ready_i && (wait_cnt == WAIT_LIMIT);
    assign boundary_next = bus.stop_i ? S_IDLE : S_FETCH;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            err_q       <= ERR_NONE;
            rtype_alu_q <= ALU_AND;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (wait_state && !bus.mem_ready_i)
                wait_cnt <= wait_cnt + 16'd1;
            if ((state_next == S_ERROR) && (state != S_ERROR))
                err_q <= err_next;
            // funct may change once the write-back starts; keep the decoded operation
            if (state == S_RTYPE_EX)
                rtype_alu_q <= funct_alu;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = ERR_NONE;
        case (state)
            S_IDLE:  if (bus.start_i) state_next = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready_i) state_next = S_DECODE;
                else if (timeout) begin
                    state_next = S_ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (bus.op_i)
                    OP_RTYPE:      state_next = S_RTYPE_EX;
                    OP_ADDI:       state_next = S_ADDI_EX;
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_BEQ:        state_next = S_BEQ;
                    OP_J:          state_next = S_JUMP;
                    OP_BNE: begin
                        if (BNE_EN) state_next = S_BNE;
                        else begin
                            state_next = S_ERROR;
                            err_next   = ERR_OP;
                        end
                    end
                    default: begin
                        state_next = S_ERROR;
                        err_next   = ERR_OP;
                    end
                endcase
            end
            S_MEMADR: begin
                if (bus.op_i == OP_LW)      state_next = S_MEMRD;
                else if (bus.op_i == OP_SW) state_next = S_MEMWR;
                else begin
                    state_next = S_ERROR;
                    err_next   = ERR_OP;
                end
            end
            S_MEMRD: begin
                if (bus.mem_ready_i) state_next = S_MEMWB;
                else if (timeout) begin
                    state_next = S_ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ready_i) state_next = boundary_next;
                else if (timeout) begin
                    state_next = S_ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_RTYPE_EX: begin
                if (funct_ok) state_next = S_RTYPE_WB;
                else begin
                    state_next = S_ERROR;
                    err_next   = ERR_FUNCT;
                end
            end
            S_ADDI_EX: state_next = S_ADDI_WB;
            S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BEQ, S_BNE, S_JUMP: state_next = boundary_next;
            S_ERROR:   state_next = S_ERROR;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_srca   = 1'b0;
        bus.alu_srcb   = 2'b00;
        bus.alu_op     = ALU_AND;
        bus.pc_src     = 2'b00;
        case (state)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                bus.alu_srcb = 2'b01;
                bus.alu_op   = ALU_ADD;
                bus.pc_write = bus.mem_ready_i;
                bus.ir_write = bus.mem_ready_i;
            end
            S_DECODE: begin
                bus.alu_srcb = 2'b11;
                bus.alu_op   = ALU_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                bus.alu_srca = 1'b1;
                bus.alu_srcb = 2'b10;
                bus.alu_op   = ALU_ADD;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_RTYPE_EX: begin
                bus.alu_srca = 1'b1;
                bus.alu_op   = funct_alu;
            end
            S_RTYPE_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                bus.alu_op    = rtype_alu_q;
            end
            S_ADDI_WB: bus.reg_write = 1'b1;
            S_BEQ, S_BNE: begin
                bus.alu_srca = 1'b1;
                bus.alu_op   = ALU_SUB;
                bus.pc_src   = 2'b01;
                bus.pc_write = (state == S_BEQ) ? bus.zero : ~bus.zero;
            end
            S_JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
            end
            default: ;
        endcase
        bus.busy_o   = (state != S_IDLE) && (state != S_ERROR);
        bus.err_o    = (state == S_ERROR);
        bus.err_code = err_q;
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm with MEM_TIMEOUT = 4 (honours MC_CTRL_BNE_EN)
module tb_mc_ctrl_fsm;
    localparam int TO = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         z;
        int         cyc;
        int         rw;
        int         pcw;
        logic [3:0] aop;
        logic [1:0] ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    bit scramble_fn = 1'b0;
    logic [20:0] obs;

    mc_ctrl_fsm_if bus();
    mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign obs = {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.iord,
                  bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_srca, bus.alu_srcb,
                  bus.alu_op, bus.pc_src, bus.busy_o, bus.err_o, bus.err_code};

    // Expected vector for a running (busy, no error) cycle.
    function automatic logic [20:0] pk(input logic pcw, input logic irw, input logic mr,
                                       input logic mw, input logic io, input logic rw,
                                       input logic rd, input logic m2r, input logic sa,
                                       input logic [1:0] sb, input logic [3:0] aop,
                                       input logic [1:0] ps);
        return {pcw, irw, mr, mw, io, rw, rd, m2r, sa, sb, aop, ps, H, L, 2'b00};
    endfunction

    function automatic logic [20:0] err_v(input logic [1:0] ec);
        return {17'b0, L, H, ec};
    endfunction

    function automatic logic [20:0] fetch_v(input logic r);
        return pk(r, r, H, L, L, L, L, L, L, 2'b01, A_ADD, 2'b00);
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] ref_funct(input logic [5:0] f);
        case (f)
            6'h20:   return {H, A_ADD};
            6'h22:   return {H, A_SUB};
            6'h24:   return {H, A_AND};
            6'h25:   return {H, A_OR};
            6'h2A:   return {H, A_SLT};
            default: return 5'b0;
        endcase
    endfunction

    task automatic step(input bit rdy, input bit z, input bit stp, input bit strt,
                        input logic [20:0] e, input string nm);
        @(negedge clk);
        bus.mem_ready_i = rdy;
        bus.zero        = z;
        bus.stop_i      = stp;
        bus.start_i     = strt;
        if (scramble_fn) bus.funct_i = 6'($urandom_range(0, 63));
        #1;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL %s got=%06h exp=%06h", nm, obs, e);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.start_i = rb(); bus.stop_i = rb(); bus.mem_ready_i = rb(); bus.zero = rb();
        @(negedge clk);
        #1;
        checks++;
        if (obs !== 21'h0) begin
            failures++;
            $display("FAIL reset got=%06h exp=%06h", obs, 21'h0);
        end
        rst_n = 1'b1;
        bus.start_i = 1'b0;
    endtask

    task automatic mid(input logic [20:0] e, input string nm);
        step(rb(), rb(), rb(), rb(), e, nm);
    endtask

    task automatic bnd(input logic [20:0] e, input bit z, input bit stp, input string nm);
        step(rb(), z, stp, rb(), e, nm);
    endtask

    // Instruction-level reference: expected per-cycle control for one instruction, starting in FETCH.
    task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                              input int fw, input int mw, input bit stp, output logic [1:0] ec);
        logic [4:0]  fa;
        logic [20:0] memrd_v;
        logic [20:0] memwr_v;
        memrd_v = pk(L, L, H, L, H, L, L, L, L, 2'b00, A_AND, 2'b00);
        memwr_v = pk(L, L, L, H, H, L, L, L, L, 2'b00, A_AND, 2'b00);
        ec = 2'b00;
        bus.op_i = op;
        bus.funct_i = fn;
        for (int i = 0; i < fw && i < TO; i++) step(1'b0, rb(), rb(), rb(), fetch_v(L), "fetch_wait");
        if (fw >= TO) begin
            ec = 2'b11;
            mid(err_v(ec), "fetch_timeout");
            return;
        end
        step(1'b1, rb(), rb(), rb(), fetch_v(H), "fetch");
        mid(pk(L, L, L, L, L, L, L, L, L, 2'b11, A_ADD, 2'b00), "decode");
        case (op)
            6'h00: begin
                fa = ref_funct(fn);
                if (fa[4]) begin
                    mid(pk(L, L, L, L, L, L, L, L, H, 2'b00, fa[3:0], 2'b00), "rtype_ex");
                    scramble_fn = 1'b1;
                    bnd(pk(L, L, L, L, L, H, H, L, L, 2'b00, fa[3:0], 2'b00), z, stp, "rtype_wb");
                    scramble_fn = 1'b0;
                end else begin
                    mid(pk(L, L, L, L, L, L, L, L, H, 2'b00, A_AND, 2'b00), "rtype_ex_bad");
                    ec = 2'b10;
                    mid(err_v(ec), "funct_error");
                end
            end
            6'h08: begin
                mid(pk(L, L, L, L, L, L, L, L, H, 2'b10, A_ADD, 2'b00), "addi_ex");
                bnd(pk(L, L, L, L, L, H, L, L, L, 2'b00, A_AND, 2'b00), z, stp, "addi_wb");
            end
            6'h23, 6'h2B: begin
                mid(pk(L, L, L, L, L, L, L, L, H, 2'b10, A_ADD, 2'b00), "memadr");
                for (int i = 0; i < mw && i < TO; i++)
                    step(1'b0, rb(), rb(), rb(), (op == 6'h23) ? memrd_v : memwr_v, "mem_wait");
                if (mw >= TO) begin
                    ec = 2'b11;
                    mid(err_v(ec), "mem_timeout");
                end else if (op == 6'h23) begin
                    step(1'b1, rb(), rb(), rb(), memrd_v, "memrd");
                    bnd(pk(L, L, L, L, L, H, L, H, L, 2'b00, A_AND, 2'b00), z, stp, "memwb");
                end else begin
                    step(1'b1, rb(), stp, rb(), memwr_v, "memwr");
                end
            end
            6'h04: bnd(pk(z, L, L, L, L, L, L, L, H, 2'b00, A_SUB, 2'b01), z, stp, "beq");
`ifdef MC_CTRL_BNE_EN
            6'h05: bnd(pk(~z, L, L, L, L, L, L, L, H, 2'b00, A_SUB, 2'b01), z, stp, "bne");
`endif
            6'h02: bnd(pk(H, L, L, L, L, L, L, L, L, 2'b00, A_AND, 2'b10), z, stp, "jump");
            default: begin
                ec = 2'b01;
                mid(err_v(ec), "op_error");
            end
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t        tbl[13];
        logic [5:0]  lf[5];
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  aop;
        logic [1:0]  ec;
        int          n, rw, pcw, fw, mw;
        bit          stp;

        tbl[0]  = '{6'h00, 6'h20, 1'b0, 4, 1, 1, A_ADD, 2'b00};
        tbl[1]  = '{6'h00, 6'h22, 1'b0, 4, 1, 1, A_SUB, 2'b00};
        tbl[2]  = '{6'h00, 6'h24, 1'b0, 4, 1, 1, A_AND, 2'b00};
        tbl[3]  = '{6'h00, 6'h25, 1'b0, 4, 1, 1, A_OR,  2'b00};
        tbl[4]  = '{6'h00, 6'h2A, 1'b0, 4, 1, 1, A_SLT, 2'b00};
        tbl[5]  = '{6'h08, 6'h00, 1'b0, 4, 1, 1, A_AND, 2'b00};
        tbl[6]  = '{6'h23, 6'h00, 1'b0, 5, 1, 1, A_AND, 2'b00};
        tbl[7]  = '{6'h2B, 6'h00, 1'b0, 4, 0, 1, A_AND, 2'b00};
        tbl[8]  = '{6'h04, 6'h00, 1'b1, 3, 0, 2, A_AND, 2'b00};
        tbl[9]  = '{6'h04, 6'h00, 1'b0, 3, 0, 1, A_AND, 2'b00};
        tbl[10] = '{6'h3F, 6'h00, 1'b0, 2, 0, 1, A_AND, 2'b01};
        tbl[11] = '{6'h00, 6'h00, 1'b0, 3, 0, 1, A_AND, 2'b10};
`ifdef MC_CTRL_BNE_EN
        tbl[12] = '{6'h05, 6'h00, 1'b0, 3, 0, 2, A_AND, 2'b00};
`else
        tbl[12] = '{6'h05, 6'h00, 1'b0, 2, 0, 1, A_AND, 2'b01};
`endif
        lf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.op_i = 6'h00; bus.funct_i = 6'h00;
        bus.zero = 1'b0; bus.mem_ready_i = 1'b0;
        repeat (2) @(negedge clk);

        // Whole-instruction table: ready high, stop held so each run ends after one instruction.
        for (int k = 0; k < 13; k++) begin
            do_reset();
            bus.op_i = tbl[k].op; bus.funct_i = tbl[k].fn; bus.zero = tbl[k].z;
            bus.stop_i = 1'b1; bus.mem_ready_i = 1'b1;
            @(negedge clk); bus.start_i = 1'b1;
            @(negedge clk); bus.start_i = 1'b0;
            #1;
            n = 0; rw = 0; pcw = 0; aop = A_AND;
            while (bus.busy_o && n < 20) begin
                n++;
                if (bus.reg_write) begin rw++; aop = bus.alu_op; end
                if (bus.pc_write) pcw++;
                @(negedge clk); #1;
            end
            chk($sformatf("tbl%0d_cycles", k), n, tbl[k].cyc);
            chk($sformatf("tbl%0d_reg_write", k), rw, tbl[k].rw);
            chk($sformatf("tbl%0d_pc_write", k), pcw, tbl[k].pcw);
            chk($sformatf("tbl%0d_wb_alu_op", k), int'(aop), int'(tbl[k].aop));
            chk($sformatf("tbl%0d_err", k), int'({bus.err_o, bus.err_code}),
                int'({tbl[k].ec != 2'b00, tbl[k].ec}));
        end

        // lw with three ready-low cycles in MEMRD, then stop to IDLE.
        do_reset();
        step(rb(), rb(), rb(), 1'b1, 21'h0, "idle_start");
        exec_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b1, ec);
        step(rb(), rb(), rb(), 1'b0, 21'h0, "lw_idle");

        // ready arriving on the fourth fetch cycle wins over the watchdog.
        step(rb(), rb(), rb(), 1'b1, 21'h0, "idle_start");
        exec_instr(6'h02, 6'h00, 1'b0, 3, 0, 1'b1, ec);
        step(rb(), rb(), rb(), 1'b0, 21'h0, "late_ready_idle");

        // Fetch timeout, then error is sticky against start/stop until reset.
        step(rb(), rb(), rb(), 1'b1, 21'h0, "idle_start");
        exec_instr(6'h08, 6'h00, 1'b0, TO, 0, 1'b0, ec);
        repeat (3) step(rb(), rb(), rb(), 1'b1, err_v(2'b11), "error_sticky");
        do_reset();

        // addi with stop raised during execute: write-back completes, then IDLE.
        step(rb(), rb(), rb(), 1'b1, 21'h0, "idle_start");
        exec_instr(6'h08, 6'h00, 1'b0, 0, 0, 1'b1, ec);
        step(rb(), rb(), rb(), 1'b0, 21'h0, "addi_stop_idle");

        // Reset while a store waits for memory must drop mem_write at once.
        step(rb(), rb(), rb(), 1'b1, 21'h0, "idle_start");
        bus.op_i = 6'h2B;
        step(1'b1, rb(), rb(), rb(), fetch_v(H), "sw_fetch");
        mid(pk(L, L, L, L, L, L, L, L, L, 2'b11, A_ADD, 2'b00), "sw_decode");
        mid(pk(L, L, L, L, L, L, L, L, H, 2'b10, A_ADD, 2'b00), "sw_memadr");
        repeat (2) step(1'b0, rb(), rb(), rb(), pk(L, L, L, H, H, L, L, L, L, 2'b00, A_AND, 2'b00), "sw_wait");
        do_reset();

        // Random instruction stream against the instruction-level reference.
        step(rb(), rb(), rb(), 1'b1, 21'h0, "idle_start");
        for (int it = 0; it < 300; it++) begin
            fn = lf[$urandom_range(0, 4)];
            case ($urandom_range(0, 11))
                0, 1:    op = 6'h00;
                2: begin op = 6'h00; fn = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(0, 63)); end
                3:       op = 6'h08;
                4, 10:   op = 6'h23;
                5:       op = 6'h2B;
                6, 11:   op = 6'h04;
                7:       op = 6'h02;
                8:       op = 6'h05;
                default: op = 6'($urandom_range(0, 63));
            endcase
            fw  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
            mw  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
            stp = ($urandom_range(0, 3) == 0);
            exec_instr(op, fn, rb(), fw, mw, stp, ec);
            if (ec != 2'b00) begin
                repeat (2) mid(err_v(ec), "error_hold");
                do_reset();
                step(rb(), rb(), rb(), 1'b1, 21'h0, "idle_start");
            end else if (stp) begin
                repeat ($urandom_range(0, 2)) step(rb(), rb(), rb(), 1'b0, 21'h0, "idle");
                step(rb(), rb(), rb(), 1'b1, 21'h0, "idle_start");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
